// File: rtl/shift_sequencer_if.sv
// Bus between the main control unit / shift-amount mux and shift_sequencer.
// The master side issues requests and supplies the mux output; the slave side
// is the sequencer.
interface shift_sequencer_if;
  logic        start;
  logic [1:0]  op;
  logic [1:0]  amt_src;
  logic [31:0] data_in;
  logic [1:0]  shamt_sel;
  logic [4:0]  shamt;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] result;

  modport master (
    output start, op, amt_src, data_in, shamt,
    input  shamt_sel, busy, done, err, result
  );

  modport slave (
    input  start, op, amt_src, data_in, shamt,
    output shamt_sel, busy, done, err, result
  );
endinterface

// File: rtl/shift_sequencer.sv
// Multicycle shift controller: sequences one SLL/SRL/SRA (optionally ROR)
// instruction at a time, one bit per cycle.
// Build option: define SHIFT_SEQ_ROTATE_EN to make op=11 a rotate right;
// otherwise op=11 is rejected with an err pulse.
module shift_sequencer (
  input logic              i_clk,
  input logic              i_reset_n,
  shift_sequencer_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StLoad, StShift, StDone} state_e;

  state_e      r_state;
  state_e      w_state_next;
  logic [31:0] r_shreg;
  logic [1:0]  r_op;
  logic [1:0]  r_shamt_sel;
  logic [4:0]  r_count;
  logic        r_err;

  logic        w_legal;
  logic        w_accept;
  logic        w_reject;
  logic [31:0] w_shifted;

  // Classify the incoming request; amt_src=11 is never legal
  always_comb begin
    w_legal = (bus.amt_src != 2'b11);
`ifndef SHIFT_SEQ_ROTATE_EN
    if (bus.op == 2'b11) begin
      w_legal = 1'b0;
    end
`endif
  end

  assign w_accept = (r_state == StIdle) && bus.start && w_legal;
  assign w_reject = (r_state == StIdle) && bus.start && !w_legal;

  // State register
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:  if (w_accept) w_state_next = StLoad;
      StLoad:  w_state_next = (bus.shamt == 5'd0) ? StDone : StShift;
      // Count is never 0 here: LOAD skips straight to DONE for a zero amount
      StShift: if (r_count == 5'd1) w_state_next = StDone;
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // One-bit shift of the operand according to the captured op
  always_comb begin
    case (r_op)
      2'b00:   w_shifted = {r_shreg[30:0], 1'b0};
      2'b01:   w_shifted = {1'b0, r_shreg[31:1]};
      2'b10:   w_shifted = {r_shreg[31], r_shreg[31:1]};
`ifdef SHIFT_SEQ_ROTATE_EN
      default: w_shifted = {r_shreg[0], r_shreg[31:1]};
`else
      // op=11 is never accepted; share the SRL path so no rotate logic exists
      default: w_shifted = {1'b0, r_shreg[31:1]};
`endif
    endcase
  end

  // Datapath registers: operand, op, mux select, count, reject pulse
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_shreg     <= 32'd0;
      r_op        <= 2'b00;
      r_shamt_sel <= 2'b00;
      r_count     <= 5'd0;
      r_err       <= 1'b0;
    end else begin
      r_err <= w_reject;
      case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_shreg     <= bus.data_in;
            r_op        <= bus.op;
            r_shamt_sel <= bus.amt_src;
          end
        end
        StLoad: begin
          r_count <= bus.shamt;
        end
        StShift: begin
          r_shreg <= w_shifted;
          r_count <= r_count - 5'd1;
        end
        default: begin
        end
      endcase
    end
  end

  // Outputs decoded purely from registered state
  always_comb begin
    bus.busy      = (r_state != StIdle);
    bus.done      = (r_state == StDone);
    bus.err       = r_err;
    bus.shamt_sel = r_shamt_sel;
    bus.result    = r_shreg;
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer: stimulus pushes the expected done/err
// event (kind, result, cycle); a negedge monitor pops and compares it.
module tb_shift_sequencer;

  logic clk;
  logic rst_n;
  int   n_edges;
  int   n_tests;
  int   n_fail;
  logic [4:0] instr_amt;
  logic [4:0] rs_amt;

  typedef struct {
    logic        done;
    logic        err;
    logic [31:0] res;
    int          at;
  } exp_t;

  exp_t exp_q[$];

  shift_sequencer_if bus ();

  shift_sequencer dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (bus.slave)
  );

  // Model of the 3-to-1 shift-amount mux
  assign bus.shamt = (bus.shamt_sel == 2'b00) ? instr_amt :
                     (bus.shamt_sel == 2'b01) ? rs_amt :
                     (bus.shamt_sel == 2'b10) ? 5'd16 : 5'd0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) n_edges <= n_edges + 1;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Monitor: every done/err pulse must match the oldest expected event
  always @(negedge clk) begin
    if (rst_n && (bus.done === 1'b1 || bus.err === 1'b1)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {30'd0, bus.done, bus.err}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("pulse_kind", {30'd0, bus.done, bus.err}, {30'd0, e.done, e.err});
        check("pulse_result", bus.result, e.res);
        check("pulse_cycle", n_edges, e.at);
      end
    end
  end

  // Legal request of amount n; optionally re-pulse start in cycles 2 and n+2
  task automatic run_op(input logic [1:0] op, input logic [1:0] src,
                        input logic [31:0] data, input logic [4:0] ins,
                        input logic [4:0] rs, input int n,
                        input logic [31:0] exp_res, input bit repulse);
    int   a0;
    exp_t e;
    @(negedge clk);
    instr_amt   = ins;
    rs_amt      = rs;
    bus.op      = op;
    bus.amt_src = src;
    bus.data_in = data;
    bus.start   = 1'b1;
    a0 = n_edges;
    e.done = 1'b1; e.err = 1'b0; e.res = exp_res; e.at = a0 + n + 2;
    exp_q.push_back(e);
    for (int c = 1; c <= n + 3; c++) begin
      @(negedge clk);
      bus.start = repulse && (c == 2 || c == n + 2);
      if (c == 1) check("shamt_sel_c1", {30'd0, bus.shamt_sel}, {30'd0, src});
      if (c == 1 || c == n + 2 || c == n + 3)
        check("busy", {31'd0, bus.busy}, {31'd0, (c <= n + 2)});
    end
    check("result_hold", bus.result, exp_res);
    check("done_seen", exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Illegal request: err in cycle 1, nothing else changes
  task automatic run_bad(input logic [1:0] op, input logic [1:0] src,
                         input logic [31:0] prev_res, input logic [1:0] prev_sel);
    int   a0;
    exp_t e;
    @(negedge clk);
    bus.op      = op;
    bus.amt_src = src;
    bus.data_in = 32'h5A5A_5A5A;
    bus.start   = 1'b1;
    a0 = n_edges;
    e.done = 1'b0; e.err = 1'b1; e.res = prev_res; e.at = a0 + 1;
    exp_q.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    check("bad_busy_c1", {31'd0, bus.busy}, 32'd0);
    repeat (2) @(negedge clk);
    check("bad_busy_c3", {31'd0, bus.busy}, 32'd0);
    check("bad_result", bus.result, prev_res);
    check("bad_sel", {30'd0, bus.shamt_sel}, {30'd0, prev_sel});
    check("err_seen", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    n_edges     = 0;
    n_tests     = 0;
    n_fail      = 0;
    rst_n       = 1'b0;
    instr_amt   = 5'd0;
    rs_amt      = 5'd0;
    bus.start   = 1'b0;
    bus.op      = 2'b00;
    bus.amt_src = 2'b00;
    bus.data_in = 32'd0;
    repeat (3) @(negedge clk);
    check("rst_result", bus.result, 32'd0);
    check("rst_flags", {29'd0, bus.busy, bus.done, bus.err}, 32'd0);
    check("rst_sel", {30'd0, bus.shamt_sel}, 32'd0);
    rst_n = 1'b1;

    run_op(2'b00, 2'b00, 32'h0000_00F1, 5'd4, 5'd9, 4, 32'h0000_0F10, 1'b0);
    run_op(2'b10, 2'b01, 32'h8000_0000, 5'd2, 5'd31, 31, 32'hFFFF_FFFF, 1'b0);
    run_op(2'b01, 2'b01, 32'h8000_0000, 5'd2, 5'd31, 31, 32'h0000_0001, 1'b0);
    run_op(2'b00, 2'b10, 32'h0000_1234, 5'd7, 5'd3, 16, 32'h1234_0000, 1'b0);
    run_op(2'b00, 2'b00, 32'hDEAD_BEEF, 5'd0, 5'd6, 0, 32'hDEAD_BEEF, 1'b0);
    run_op(2'b00, 2'b01, 32'h0000_000F, 5'd8, 5'd3, 3, 32'h0000_0078, 1'b1);
    run_bad(2'b00, 2'b11, 32'h0000_0078, 2'b01);

    // Reset in cycle 5 of a 10-bit shift
    @(negedge clk);
    instr_amt   = 5'd10;
    bus.op      = 2'b00;
    bus.amt_src = 2'b00;
    bus.data_in = 32'h0000_0001;
    bus.start   = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_result", bus.result, 32'd0);
    check("midrst_flags", {29'd0, bus.busy, bus.done, bus.err}, 32'd0);
    check("midrst_sel", {30'd0, bus.shamt_sel}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op(2'b01, 2'b01, 32'hF000_0000, 5'd1, 5'd5, 5, 32'h0780_0000, 1'b0);
`ifdef SHIFT_SEQ_ROTATE_EN
    run_op(2'b11, 2'b00, 32'h0000_00AB, 5'd8, 5'd2, 8, 32'hAB00_0000, 1'b0);
`else
    run_bad(2'b11, 2'b00, 32'h0780_0000, 2'b01);
`endif

    repeat (3) @(negedge clk);
    check("final_queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Multicycle shift controller for the CPU datapath. It sequences one shift instruction at a time (SLL/SRL/SRA, optional ROR). It drives the select of the 3-to-1 5-bit shift-amount mux, captures the selected amount, and shifts a 32-bit operand one bit per cycle until the count is exhausted. It sits between the main control unit, which issues `start`, and the shift-amount mux and result path.

## Interface
No parameters; widths are fixed (32-bit data, 5-bit amount).
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- start  in  1  request pulse; sampled only in IDLE
- op  in  2  00 SLL, 01 SRL, 10 SRA, 11 ROR (see Configuration)
- amt_src  in  2  amount source: 00 instruction shamt, 01 rs[4:0], 10 constant 16; 11 illegal
- data_in  in  32  operand, sampled with `start`
- shamt_sel  out  2  drives shift-amount mux select
- shamt  in  5  shift-amount mux output
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse, result valid
- err  out  1  one-cycle pulse, illegal request rejected
- result  out  32  shift register contents

## Operation
- States: IDLE, LOAD, SHIFT, DONE.
- IDLE:
  - `start`=1 with legal op/amt_src: register `data_in` into the shift register, `op` into the op register, `amt_src` into `shamt_sel`; go to LOAD.
  - Illegal request (amt_src=11, or op=11 without the macro): pulse `err` next cycle, stay IDLE; shift register and `shamt_sel` unchanged.
- LOAD: `shamt_sel` stable. At edge, count <= `shamt`. Go to DONE if `shamt`=0, else SHIFT.
- SHIFT: each edge shifts one bit and decrements count. When count=1 at edge, go to DONE.
  - SLL: fill bit0 with 0.
  - SRL: fill bit31 with 0.
  - SRA: fill bit31 with old bit31.
  - ROR: bit31 <= old bit0.
- DONE: `done`=1 for this cycle only; next edge goes to IDLE.
- `result` is the shift register itself. It holds its value after DONE until the next accepted `start`.
- `start` outside IDLE is ignored and not queued, including during DONE.
- Count is 5 bits; max amount 31; no wrap.

## Timing
- Reset values: state IDLE, `shamt_sel`=00, `busy`=0, `done`=0, `err`=0, `result`=0, count=0.
- `busy`, `done`, `err` and `shamt_sel` are registered-state outputs with no combinational path from inputs.
- Cycle numbering: the edge sampling `start` is E0. Cycle c is the cycle between edge E(c-1) and edge Ec.
- Cycle 1: LOAD. The mux select is valid for the whole cycle; `shamt` is captured at E1.
- Amount N>0: shifts on E2..E(N+1). `done` is high in cycle N+2, and `busy` is high in cycles 1..N+2.
- Amount N=0: `done` is high in cycle 2; `result` equals `data_in`.
- Back-to-back: the next `start` is accepted at the edge ending the first IDLE cycle after DONE. Minimum issue interval is N+3 cycles.
- Illegal request: `err` is high in cycle 1, `busy` stays 0.
- Reset asserted mid-operation:
  - All registers clear immediately (asynchronous), with no `done` or `err` pulse.
  - Release is synchronized externally; the first `start` is sampled at the first rising edge with `reset_n`=1.

## Configuration
- Macro `SHIFT_SEQ_ROTATE_EN`.
- Defined: op=11 performs rotate right by N, one bit per cycle, with normal timing.
- Undefined: op=11 is illegal and gives an `err` pulse with no state change. No rotate logic is synthesized.

## Test plan
- SLL, amt_src=00, `shamt`=4, `data_in`=0x000000F1. Required:
  - `shamt_sel`=00 in cycle 1.
  - `result`=0x00000F10, `done` in cycle 6, `busy` high in cycles 1–6.
- SRA, amt_src=01, `shamt`=31, `data_in`=0x80000000. Required: `result`=0xFFFFFFFF, `done` in cycle 33. Repeat with SRL: `result`=0x00000001.
- amt_src=10 (mux returns 16), SLL, `data_in`=0x00001234. Required: `shamt_sel`=10, `result`=0x12340000, `done` in cycle 18. Also `shamt`=0 case: `result`=`data_in`, `done` in cycle 2.
- `start` re-pulsed in cycles 2 and N+2 of an SLL by 3. Required: both ignored, a single `done`, result unaffected. Illegal amt_src=11: `err` in cycle 1, `busy` stays 0, `result` unchanged.
- `reset_n` low in cycle 5 of a 10-bit shift. Required: `result`=0, `busy`=0, `shamt_sel`=00 immediately, no `done`. A new request after release completes normally.
- op=11, `shamt`=8, `data_in`=0x000000AB. With `SHIFT_SEQ_ROTATE_EN`: `result`=0xAB000000, `done` in cycle 10. Without it: `err` in cycle 1, no `done`.
